// File: rtl/fwd_hazard_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
//   SEL_*     : forwarding select encoding (0 = register file, k = pipeline reg k)
//   shadow_t  : one in-flight destination tracked past ID
package fwd_hazard_pkg;

   localparam int SEL_REGFILE = 0;
   localparam int SEL_EX_MEM  = 1;
   localparam int SEL_MEM_WB  = 2;

   // Destination field is stored at a fixed width so the entry type can live
   // here; instances must use ADDR_W <= SHADOW_RD_W. The unused upper bits are
   // always zero and drop out in synthesis.
   localparam int SHADOW_RD_W = 16;

   typedef struct packed {
      logic                   valid;
      logic [SHADOW_RD_W-1:0] rd;
      logic                   wr_en;
      logic                   is_load;
   } shadow_t;

endpackage

// File: rtl/fwd_src_match.sv
// Priority compare of one ALU source address against the shadow pipeline.
//   src_i      : source register address
//   used_i     : source is actually read
//   shadow_i   : shadow stages 1..FWD_DEPTH (1 = EX, youngest)
//   sel_o      : youngest matching stage, 0 if none (register file)
//   load_haz_o : youngest match is a load whose data is not yet forwardable
module fwd_src_match
   import fwd_hazard_pkg::*;
#(
   parameter  int ADDR_W    = 6,
   parameter  int FWD_DEPTH = 2,
   parameter  int LOAD_LAT  = 1,
   parameter  int ZERO_REG  = 0,
   localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
   input  logic [ADDR_W-1:0]      src_i,
   input  logic                   used_i,
   input  shadow_t [FWD_DEPTH:1]  shadow_i,
   output logic [SEL_W-1:0]       sel_o,
   output logic                   load_haz_o
);

   logic               src_is_zero;
   logic [FWD_DEPTH:1] match;

   assign src_is_zero = (ZERO_REG != 0) && (src_i == '0);

   for (genvar k = 1; k <= FWD_DEPTH; k++) begin : g_cmp
      assign match[k] = used_i & shadow_i[k].valid & shadow_i[k].wr_en &
                        (shadow_i[k].rd == SHADOW_RD_W'(src_i)) & ~src_is_zero;
   end

   // Walk oldest to youngest so the youngest match overwrites; the hazard flag
   // follows the same winner, so a younger ALU write shadows an older load.
   always_comb begin
      sel_o      = SEL_W'(SEL_REGFILE);
      load_haz_o = 1'b0;
      for (int k = FWD_DEPTH; k >= 1; k--) begin
         if (match[k]) begin
            sel_o      = SEL_W'(k);
            load_haz_o = shadow_i[k].is_load && (k <= LOAD_LAT);
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding + load-use hazard unit between ID and EX.
//   clk_i, rst_n_i       : clock, synchronous active-low reset
//   id_valid_i           : valid instruction in ID
//   id_src_i             : source addresses, src i at [i*ADDR_W +: ADDR_W]
//   id_src_used_i        : per-source read enable
//   id_rd_i, id_wr_en_i  : destination and its write enable
//   id_is_load_i         : result comes from memory
//   flush_i              : squash the instruction in ID
//   stall_o              : combinational stall of PC/IF/ID (bubble into EX)
//   ex_valid_o           : registered, instruction now in EX is real
//   ex_src_sel_o         : registered forward select per source
//   stall_cnt_o          : saturating stall-cycle counter
module fwd_hazard_unit
   import fwd_hazard_pkg::*;
#(
   parameter  int ADDR_W    = 6,
   parameter  int NUM_SRC   = 2,
   parameter  int FWD_DEPTH = 2,
   parameter  int LOAD_LAT  = 1,
   parameter  int ZERO_REG  = 0,
   parameter  int CNT_W     = 16,
   localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       id_valid_i,
   input  logic [NUM_SRC*ADDR_W-1:0]  id_src_i,
   input  logic [NUM_SRC-1:0]         id_src_used_i,
   input  logic [ADDR_W-1:0]          id_rd_i,
   input  logic                       id_wr_en_i,
   input  logic                       id_is_load_i,
   input  logic                       flush_i,
   output logic                       stall_o,
   output logic                       ex_valid_o,
   output logic [NUM_SRC*SEL_W-1:0]   ex_src_sel_o,
   output logic [CNT_W-1:0]           stall_cnt_o
);

   shadow_t [FWD_DEPTH:1]        shadow_q, shadow_d;
   logic [NUM_SRC-1:0][SEL_W-1:0] sel;
   logic [NUM_SRC-1:0]           load_haz;
   logic                         issue;

   logic                         ex_valid_q, ex_valid_d;
   logic [NUM_SRC*SEL_W-1:0]     ex_src_sel_q, ex_src_sel_d;
   logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_match #(
         .ADDR_W    (ADDR_W),
         .FWD_DEPTH (FWD_DEPTH),
         .LOAD_LAT  (LOAD_LAT),
         .ZERO_REG  (ZERO_REG)
      ) u_match (
         .src_i      (id_src_i[i*ADDR_W +: ADDR_W]),
         .used_i     (id_src_used_i[i]),
         .shadow_i   (shadow_q),
         .sel_o      (sel[i]),
         .load_haz_o (load_haz[i])
      );
   end

   // Flush wins over stall: a squashed instruction has no hazard to wait on.
   assign stall_o = id_valid_i & ~flush_i & (|load_haz);
   assign issue   = id_valid_i & ~stall_o & ~flush_i;

   // Shadow pipeline: back end never stalls, so it always shifts; a bubble
   // enters stage 1 whenever ID does not issue.
   always_comb begin
      shadow_d = '0;
      if (issue) begin
         shadow_d[1].valid   = 1'b1;
         shadow_d[1].rd      = SHADOW_RD_W'(id_rd_i);
         shadow_d[1].wr_en   = id_wr_en_i;
         shadow_d[1].is_load = id_is_load_i;
      end
      for (int k = 2; k <= FWD_DEPTH; k++) begin
         shadow_d[k] = shadow_q[k-1];
      end
   end

   always_comb begin
      ex_valid_d   = issue;
      ex_src_sel_d = '0;
      if (issue) ex_src_sel_d = sel;
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         shadow_q     <= '0;
         ex_valid_q   <= 1'b0;
         ex_src_sel_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         shadow_q     <= shadow_d;
         ex_valid_q   <= ex_valid_d;
         ex_src_sel_q <= ex_src_sel_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign ex_valid_o   = ex_valid_q;
   assign ex_src_sel_o = ex_src_sel_q;
   assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a default instance (a) and a deeper
// instance (b: FWD_DEPTH=3, LOAD_LAT=2, ZERO_REG=1, CNT_W=2) share inputs.
module tb_fwd_hazard_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [11:0] id_src;
   logic [1:0]  id_src_used;
   logic [5:0]  id_rd;
   logic        id_wr_en, id_is_load, flush;

   logic        stall_a, ev_a, stall_b, ev_b;
   logic [3:0]  sel_a, sel_b;
   logic [15:0] cnt_a;
   logic [1:0]  cnt_b;

   logic        stall_m, ev_m;
   logic [3:0]  sel_m;
   bit          use_b = 1'b0;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit         v;
      logic [1:0] s0;
      logic [1:0] s1;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   fwd_hazard_unit u_dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid), .id_src_i(id_src),
      .id_src_used_i(id_src_used), .id_rd_i(id_rd), .id_wr_en_i(id_wr_en),
      .id_is_load_i(id_is_load), .flush_i(flush), .stall_o(stall_a),
      .ex_valid_o(ev_a), .ex_src_sel_o(sel_a), .stall_cnt_o(cnt_a)
   );

   fwd_hazard_unit #(.FWD_DEPTH(3), .LOAD_LAT(2), .ZERO_REG(1), .CNT_W(2)) u_dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid), .id_src_i(id_src),
      .id_src_used_i(id_src_used), .id_rd_i(id_rd), .id_wr_en_i(id_wr_en),
      .id_is_load_i(id_is_load), .flush_i(flush), .stall_o(stall_b),
      .ex_valid_o(ev_b), .ex_src_sel_o(sel_b), .stall_cnt_o(cnt_b)
   );

   assign stall_m = use_b ? stall_b : stall_a;
   assign ev_m    = use_b ? ev_b    : ev_a;
   assign sel_m   = use_b ? sel_b   : sel_a;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      id_valid = 0; id_src = '0; id_src_used = '0; id_rd = '0;
      id_wr_en = 0; id_is_load = 0; flush = 0;
   endtask

   // One ID cycle: drive at negedge, check combinational stall, queue the
   // expected EX outputs, then pop and compare them after the edge.
   task automatic step(input string tag, input bit v, input [5:0] s0, input [5:0] s1,
                       input [1:0] used, input [5:0] rd, input bit wr, input bit ld,
                       input bit fl, input bit e_stall, input bit e_v,
                       input [1:0] e0, input [1:0] e1);
      exp_t e;
      id_valid = v; id_src = {s1, s0}; id_src_used = used; id_rd = rd;
      id_wr_en = wr; id_is_load = ld; flush = fl;
      #1;
      chk({tag, ".stall"}, 32'(stall_m), 32'(e_stall));
      e.v = e_v; e.s0 = e0; e.s1 = e1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      chk({tag, ".ex_valid"}, 32'(ev_m), 32'(e.v));
      chk({tag, ".ex_sel"}, 32'(sel_m), 32'({e.s1, e.s0}));
      @(negedge clk);
   endtask

   initial begin
      // Reset with random inputs
      rst_n = 0;
      id_valid = 1'($urandom); id_src = 12'($urandom); id_src_used = 2'($urandom);
      id_rd = 6'($urandom); id_wr_en = 1'($urandom); id_is_load = 1'($urandom);
      flush = 1'($urandom);
      @(posedge clk);
      id_valid = 1; id_src = 12'($urandom); id_src_used = 2'b11;
      id_wr_en = 1; id_is_load = 1; flush = 0;
      @(posedge clk); #1;
      chk("rst.stall_a", 32'(stall_a), 0);
      chk("rst.stall_b", 32'(stall_b), 0);
      chk("rst.ev_a",    32'(ev_a),    0);
      chk("rst.ev_b",    32'(ev_b),    0);
      chk("rst.sel_a",   32'(sel_a),   0);
      chk("rst.sel_b",   32'(sel_b),   0);
      chk("rst.cnt_a",   32'(cnt_a),   0);
      chk("rst.cnt_b",   32'(cnt_b),   0);
      @(negedge clk);
      rst_n = 1; idle();

      // ALU chain, priority, unused/non-writing sources (instance a)
      //        tag         v  s0 s1 used  rd wr ld fl  stl ev e0 e1
      step("alu_w5",    1, 0, 0, 2'b00, 5, 1, 0, 0,  0, 1, 0, 0);
      step("fwd_ex",    1, 5, 0, 2'b01,10, 1, 0, 0,  0, 1, 1, 0);
      step("fwd_mem",   1, 0, 5, 2'b10,11, 1, 0, 0,  0, 1, 0, 2);
      step("retired",   1, 5, 5, 2'b11,12, 0, 0, 0,  0, 1, 0, 0);
      step("no_wr",     1,12, 0, 2'b01, 7, 1, 0, 0,  0, 1, 0, 0);
      step("w7_again",  1, 0, 0, 2'b00, 7, 1, 0, 0,  0, 1, 0, 0);
      step("youngest",  1, 7, 7, 2'b11, 8, 1, 0, 0,  0, 1, 1, 1);
      step("unused",    1, 8, 8, 2'b00, 9, 0, 0, 0,  0, 1, 0, 0);

      // Load-use: one stall cycle, then forward from MEM/WB
      step("ld_r3",     1, 0, 0, 2'b00, 3, 1, 1, 0,  0, 1, 0, 0);
      step("ld_use",    1, 3, 0, 2'b01, 4, 1, 0, 0,  1, 0, 0, 0);
      step("ld_fwd",    1, 3, 0, 2'b01, 4, 1, 0, 0,  0, 1, 2, 0);
      chk("ld.cnt_a", 32'(cnt_a), 1);

      // Flush dominates stall; invalid ID never stalls
      step("ld_r3b",    1, 0, 0, 2'b00, 3, 1, 1, 0,  0, 1, 0, 0);
      step("flush",     1, 3, 0, 2'b01, 4, 1, 0, 1,  0, 0, 0, 0);
      chk("flush.cnt_a", 32'(cnt_a), 1);
      step("idle",      0, 3, 0, 2'b01, 4, 1, 0, 0,  0, 0, 0, 0);
      step("ld_r3c",    1, 0, 0, 2'b00, 3, 1, 1, 0,  0, 1, 0, 0);
      step("novalid",   0, 3, 0, 2'b01, 4, 1, 0, 0,  0, 0, 0, 0);
      step("w_r0",      1, 0, 0, 2'b00, 0, 1, 0, 0,  0, 1, 0, 0);
      step("fwd_r0",    1, 0, 0, 2'b11, 1, 0, 0, 0,  0, 1, 1, 1);
      chk("r0.cnt_a", 32'(cnt_a), 1);

      // Reset in the middle of a load-use stall
      step("ld_r3d",    1, 0, 0, 2'b00, 3, 1, 1, 0,  0, 1, 0, 0);
      id_valid = 1; id_src = 12'd3; id_src_used = 2'b01; id_rd = 6'd4;
      id_wr_en = 1; id_is_load = 0; flush = 0; rst_n = 0;
      #1;
      chk("mid.stall_pre", 32'(stall_a), 1);
      @(posedge clk); #1;
      chk("mid.stall_post", 32'(stall_a), 0);
      chk("mid.cnt_a",      32'(cnt_a),   0);
      chk("mid.ev_a",       32'(ev_a),    0);
      @(posedge clk); #1;
      chk("mid.cnt_b",      32'(cnt_b),   0);
      @(negedge clk);
      rst_n = 1; idle();

      // Deeper instance: two-cycle load latency, zero register, saturation
      use_b = 1'b1;
      step("b_ld9",     1, 0, 0, 2'b00, 9, 1, 1, 0,  0, 1, 0, 0);
      step("b_use1",    1, 9, 0, 2'b01,20, 1, 0, 0,  1, 0, 0, 0);
      step("b_use2",    1, 9, 0, 2'b01,20, 1, 0, 0,  1, 0, 0, 0);
      step("b_fwd3",    1, 9, 0, 2'b01,20, 1, 0, 0,  0, 1, 3, 0);
      chk("b.cnt2", 32'(cnt_b), 2);
      step("b_w0",      1, 0, 0, 2'b00, 0, 1, 0, 0,  0, 1, 0, 0);
      step("b_r0a",     1, 0, 0, 2'b11,21, 1, 0, 0,  0, 1, 0, 0);
      step("b_r0b",     1, 0, 0, 2'b11,22, 1, 0, 0,  0, 1, 0, 0);
      step("b_ld9b",    1, 0, 0, 2'b00, 9, 1, 1, 0,  0, 1, 0, 0);
      step("b_use3",    1, 9, 0, 2'b01,23, 1, 0, 0,  1, 0, 0, 0);
      chk("b.cnt3", 32'(cnt_b), 3);
      step("b_use4",    1, 9, 0, 2'b01,23, 1, 0, 0,  1, 0, 0, 0);
      chk("b.cnt_sat", 32'(cnt_b), 3);
      step("b_fwd3b",   1, 9, 0, 2'b01,23, 1, 0, 0,  0, 1, 3, 0);
      chk("b.cnt_hold", 32'(cnt_b), 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
